// File: rtl/sys_cmd_host.sv
// sys_cmd_host: host-side initiator for the UART register/ALU command link.
// Takes one parallel command, serialises its byte frame towards the UART TX
// front end, then gathers the 1- or 2-byte reply (low byte first) into a
// single response, or reports a timeout if the far end goes quiet.
//
// Handshakes: a transfer happens on a rising CLK edge where valid && ready.
// The sender holds valid and its payload stable until that edge; the
// receiver may drive ready freely. RX_DATA_VALID is a strobe with no ready.
module sys_cmd_host #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_SIZE     = 4,
  parameter int FUNC_WIDTH    = 4,
  parameter int ALU_OUT_WIDTH = 16,
  parameter int RSP_TIMEOUT   = 1023
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_type,
  input  logic [ADDR_SIZE-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  input  logic [DATA_WIDTH-1:0]    cmd_opb,
  input  logic [FUNC_WIDTH-1:0]    cmd_func,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_DATA_VALID,
  input  logic                     tx_ready,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_DATA_VALID,
  output logic [ALU_OUT_WIDTH-1:0] rsp_data,
  output logic                     rsp_valid,
  output logic                     rsp_timeout,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Counter only needs to hold 0..RSP_TIMEOUT-1; hitting the last value on
  // an idle cycle is the timeout.
  localparam int CW = (RSP_TIMEOUT < 2) ? 1 : $clog2(RSP_TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(RSP_TIMEOUT - 1);

  localparam logic [DATA_WIDTH-1:0] HDR_WR   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] HDR_RD   = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] HDR_ALU  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] HDR_ALUN = DATA_WIDTH'(8'hDD);

  state_t                   state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic                     rx_cnt_q, rx_cnt_d;
  logic [CW-1:0]            to_cnt_q, to_cnt_d;
  logic [1:0]               type_q, type_d;
  logic [ADDR_SIZE-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    opb_q, opb_d;
  logic [FUNC_WIDTH-1:0]    func_q, func_d;
  logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
  logic                     tx_valid_q, tx_valid_d;
  logic [ALU_OUT_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_timeout_q, rsp_timeout_d;
  logic                     alive_q;

  // Byte at position idx of the frame for a given command.
  function automatic logic [DATA_WIDTH-1:0] frame_byte(
    input logic [1:0]            t,
    input logic [ADDR_SIZE-1:0]  a,
    input logic [DATA_WIDTH-1:0] wd,
    input logic [DATA_WIDTH-1:0] ob,
    input logic [FUNC_WIDTH-1:0] fn,
    input logic [1:0]            idx
  );
    logic [DATA_WIDTH-1:0] a_x;
    logic [DATA_WIDTH-1:0] f_x;
    a_x = DATA_WIDTH'(a);
    f_x = DATA_WIDTH'(fn);
    frame_byte = '0;
    case (t)
      2'b00: frame_byte = (idx == 2'd0) ? HDR_WR : (idx == 2'd1) ? a_x : wd;
      2'b01: frame_byte = (idx == 2'd0) ? HDR_RD : a_x;
      2'b10: frame_byte = (idx == 2'd0) ? HDR_ALU : (idx == 2'd1) ? wd :
                          (idx == 2'd2) ? ob : f_x;
      default: frame_byte = (idx == 2'd0) ? HDR_ALUN : f_x;
    endcase
  endfunction

  // Index of the final byte of each frame type.
  function automatic logic [1:0] last_idx(input logic [1:0] t);
    case (t)
      2'b00:   last_idx = 2'd2;
      2'b10:   last_idx = 2'd3;
      default: last_idx = 2'd1;
    endcase
  endfunction

  // cmd_ready is the only combinational output; alive_q holds it low until
  // the first edge after reset release.
  assign cmd_ready     = alive_q && (state_q == IDLE);
  assign TX_P_DATA     = tx_data_q;
  assign TX_DATA_VALID = tx_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign dbg_state     = state_q;

  // Next-state and next-output logic for the command/response sequence.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rx_cnt_d      = rx_cnt_q;
    to_cnt_d      = to_cnt_q;
    type_d        = type_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    opb_d         = opb_q;
    func_d        = func_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          type_d     = cmd_type;
          addr_d     = cmd_addr;
          wdata_d    = cmd_wdata;
          opb_d      = cmd_opb;
          func_d     = cmd_func;
          rsp_data_d = '0;
          idx_d      = 2'd0;
          rx_cnt_d   = 1'b0;
          to_cnt_d   = '0;
          tx_data_d  = frame_byte(cmd_type, cmd_addr, cmd_wdata, cmd_opb, cmd_func, 2'd0);
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q == last_idx(type_q)) begin
            tx_valid_d = 1'b0;
            to_cnt_d   = '0;
            rx_cnt_d   = 1'b0;
            if (type_q == 2'b00) begin
              state_d     = DONE;
              rsp_valid_d = 1'b1;
            end else begin
              state_d = WAIT_RSP;
            end
          end else begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = frame_byte(type_q, addr_q, wdata_q, opb_q, func_q, idx_q + 2'd1);
          end
        end
      end
      WAIT_RSP: begin
        if (RX_DATA_VALID) begin
          // A byte arriving on the would-be timeout cycle still counts.
          to_cnt_d = '0;
          rx_cnt_d = 1'b1;
          if (!rx_cnt_q) rsp_data_d[DATA_WIDTH-1:0] = RX_P_DATA;
          else           rsp_data_d[2*DATA_WIDTH-1:DATA_WIDTH] = RX_P_DATA;
          if (rx_cnt_q || !type_q[1]) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          // Timeout pulse is shown from DONE so cmd_ready returns a cycle later.
          to_cnt_d      = '0;
          rsp_timeout_d = 1'b1;
          state_d       = DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      rx_cnt_q      <= 1'b0;
      to_cnt_q      <= '0;
      type_q        <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      opb_q         <= '0;
      func_q        <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      alive_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rx_cnt_q      <= rx_cnt_d;
      to_cnt_q      <= to_cnt_d;
      type_q        <= type_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      opb_q         <= opb_d;
      func_q        <= func_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      alive_q       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sys_cmd_host.sv
// Bench for sys_cmd_host: table of directed commands plus hand-written
// sequences for backpressure, timeouts and reset in mid-frame.
module tb_sys_cmd_host;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [3:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic [7:0]  cmd_opb;
  logic [3:0]  cmd_func;
  logic [7:0]  TX_P_DATA;
  logic        TX_DATA_VALID;
  logic        tx_ready;
  logic [7:0]  RX_P_DATA;
  logic        RX_DATA_VALID;
  logic [15:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_timeout;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  sys_cmd_host #(
    .DATA_WIDTH(8), .ADDR_SIZE(4), .FUNC_WIDTH(4), .ALU_OUT_WIDTH(16), .RSP_TIMEOUT(8)
  ) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_opb(cmd_opb), .cmd_func(cmd_func),
    .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID), .tx_ready(tx_ready),
    .RX_P_DATA(RX_P_DATA), .RX_DATA_VALID(RX_DATA_VALID),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout),
    .dbg_state(dbg_state)
  );

  // Clock generation
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]  t;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  opb;
    logic [3:0]  func;
    logic [2:0]  nb;        // frame length
    logic [31:0] tx_bytes;  // byte i in [8*i +: 8]
    logic [1:0]  nrx;       // reply bytes to send
    logic [3:0]  gap0;      // idle cycles before reply byte 0
    logic [3:0]  gap1;      // idle cycles before reply byte 1
    logic [15:0] rx_bytes;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(
    input logic [1:0] t, input logic [3:0] addr, input logic [7:0] wdata,
    input logic [7:0] opb, input logic [3:0] func, input logic [2:0] nb,
    input logic [31:0] tx_bytes, input logic [1:0] nrx, input logic [3:0] gap0,
    input logic [3:0] gap1, input logic [15:0] rx_bytes, input logic [15:0] exp
  );
    vec_t v;
    v.t = t; v.addr = addr; v.wdata = wdata; v.opb = opb; v.func = func;
    v.nb = nb; v.tx_bytes = tx_bytes; v.nrx = nrx; v.gap0 = gap0; v.gap1 = gap1;
    v.rx_bytes = rx_bytes; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!cmd_ready && k < 20) begin
      step();
      k++;
    end
    chk("cmd_ready wait", cmd_ready, 1);
  endtask

  task automatic send_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] wd,
                          input logic [7:0] ob, input logic [3:0] fn);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_opb   = ob;
    cmd_func  = fn;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    RX_P_DATA     = b;
    RX_DATA_VALID = 1'b1;
    step();
    RX_DATA_VALID = 1'b0;
  endtask

  task automatic run_vector(input vec_t v, input int id);
    logic [31:0] txb;
    logic [15:0] rxb;
    int g;
    txb = v.tx_bytes;
    rxb = v.rx_bytes;
    wait_ready();
    tx_ready = 1'b1;
    send_cmd(v.t, v.addr, v.wdata, v.opb, v.func);
    for (int i = 0; i < int'(v.nb); i++) begin
      chk($sformatf("v%0d tx_valid[%0d]", id, i), TX_DATA_VALID, 1);
      chk($sformatf("v%0d tx_byte[%0d]", id, i), TX_P_DATA, txb[8*i +: 8]);
      if (i == 0) chk($sformatf("v%0d busy", id), cmd_ready, 0);
      step();
    end
    chk($sformatf("v%0d tx_valid end", id), TX_DATA_VALID, 0);
    for (int j = 0; j < int'(v.nrx); j++) begin
      g = (j == 0) ? int'(v.gap0) : int'(v.gap1);
      for (int k = 0; k < g; k++) step();
      chk($sformatf("v%0d no early rsp[%0d]", id, j), rsp_valid, 0);
      rx_byte(rxb[8*j +: 8]);
    end
    chk($sformatf("v%0d rsp_valid", id), rsp_valid, 1);
    chk($sformatf("v%0d rsp_timeout", id), rsp_timeout, 0);
    chk($sformatf("v%0d rsp_data", id), rsp_data, v.exp);
    step();
    chk($sformatf("v%0d rsp_valid pulse", id), rsp_valid, 0);
    chk($sformatf("v%0d ready again", id), cmd_ready, 1);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Main test sequence
  initial begin
    RST = 1'b1; cmd_valid = 1'b0; cmd_type = '0; cmd_addr = '0; cmd_wdata = '0;
    cmd_opb = '0; cmd_func = '0; tx_ready = 1'b0; RX_P_DATA = '0; RX_DATA_VALID = 1'b0;

    //              t      addr   wd     ob     fn    nb  tx_bytes       nrx g0 g1 rx_bytes  exp
    vecs[0] = mk(2'b00, 4'h5, 8'h3C, 8'h00, 4'h0, 3, 32'h003C05AA, 0, 0, 0, 16'h0000, 16'h0000);
    vecs[1] = mk(2'b01, 4'hA, 8'h00, 8'h00, 4'h0, 2, 32'h00000ABB, 1, 0, 0, 16'h007E, 16'h007E);
    vecs[2] = mk(2'b10, 4'h0, 8'h12, 8'h34, 4'h2, 4, 32'h023412CC, 2, 1, 2, 16'h0308, 16'h0308);
    vecs[3] = mk(2'b11, 4'h0, 8'h00, 8'h00, 4'hF, 2, 32'h00000FDD, 2, 7, 7, 16'h80FF, 16'h80FF);
    vecs[4] = mk(2'b01, 4'h0, 8'h00, 8'h00, 4'h0, 2, 32'h000000BB, 1, 3, 0, 16'h005A, 16'h005A);
    vecs[5] = mk(2'b00, 4'hF, 8'hFF, 8'h00, 4'h0, 3, 32'h00FF0FAA, 0, 0, 0, 16'h0000, 16'h0000);

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst cmd_ready", cmd_ready, 0);
    chk("rst tx_valid", TX_DATA_VALID, 0);
    chk("rst tx_data", TX_P_DATA, 0);
    chk("rst rsp_data", rsp_data, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_timeout", rsp_timeout, 0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("ready before first edge", cmd_ready, 0);
    step();
    chk("ready after first edge", cmd_ready, 1);

    // Table-driven commands
    for (int v = 0; v < 6; v++) run_vector(vecs[v], v);

    // Backpressure with stray RX strobes during SEND
    wait_ready();
    tx_ready = 1'b0;
    send_cmd(2'b11, 4'h0, 8'h00, 8'h00, 4'h1);
    chk("bp byte0 valid", TX_DATA_VALID, 1);
    chk("bp byte0", TX_P_DATA, 8'hDD);
    step();
    chk("bp byte0 held", TX_P_DATA, 8'hDD);
    chk("bp byte0 valid held", TX_DATA_VALID, 1);
    tx_ready = 1'b1;
    RX_P_DATA = 8'h55; RX_DATA_VALID = 1'b1;
    step();
    RX_DATA_VALID = 1'b0;
    chk("bp byte1", TX_P_DATA, 8'h01);
    tx_ready = 1'b0;
    step();
    chk("bp byte1 held", TX_P_DATA, 8'h01);
    chk("bp byte1 valid held", TX_DATA_VALID, 1);
    tx_ready = 1'b1;
    RX_P_DATA = 8'h66; RX_DATA_VALID = 1'b1;
    step();
    RX_DATA_VALID = 1'b0;
    chk("bp tx done", TX_DATA_VALID, 0);
    chk("bp stray ignored", rsp_data, 16'h0000);
    rx_byte(8'h11);
    chk("bp no rsp after 1 byte", rsp_valid, 0);
    rx_byte(8'h22);
    chk("bp rsp_valid", rsp_valid, 1);
    chk("bp rsp_data", rsp_data, 16'h2211);
    step();

    // Timeout on a read with no reply
    wait_ready();
    tx_ready = 1'b1;
    send_cmd(2'b01, 4'h3, 8'h00, 8'h00, 4'h0);
    step();
    step();
    chk("to1 in wait", TX_DATA_VALID, 0);
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("to1 quiet[%0d]", k), rsp_timeout, 0);
    end
    step();
    chk("to1 pulse", rsp_timeout, 1);
    chk("to1 no rsp_valid", rsp_valid, 0);
    chk("to1 not ready yet", cmd_ready, 0);
    chk("to1 rsp_data", rsp_data, 16'h0000);
    step();
    chk("to1 pulse end", rsp_timeout, 0);
    chk("to1 ready", cmd_ready, 1);

    // Timeout on an ALU command after one reply byte
    send_cmd(2'b10, 4'h0, 8'h01, 8'h02, 4'h3);
    repeat (4) step();
    step();
    step();
    rx_byte(8'hAB);
    for (int k = 1; k < 8; k++) step();
    chk("to2 quiet", rsp_timeout, 0);
    step();
    chk("to2 pulse", rsp_timeout, 1);
    chk("to2 no rsp_valid", rsp_valid, 0);
    chk("to2 partial data", rsp_data, 16'h00AB);
    step();
    chk("to2 ready", cmd_ready, 1);

    // Reset in the middle of a frame
    send_cmd(2'b10, 4'h0, 8'h12, 8'h34, 4'h2);
    chk("mid hdr", TX_P_DATA, 8'hCC);
    step();
    chk("mid byte1", TX_P_DATA, 8'h12);
    RST = 1'b1;
    #1;
    chk("mid async valid drop", TX_DATA_VALID, 0);
    chk("mid ready low", cmd_ready, 0);
    repeat (3) step();
    chk("mid no rsp_valid", rsp_valid, 0);
    chk("mid no timeout", rsp_timeout, 0);
    chk("mid rsp_data cleared", rsp_data, 16'h0000);
    @(negedge CLK);
    RST = 1'b0;
    step();
    chk("mid ready after release", cmd_ready, 1);
    run_vector(vecs[1], 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
